// File: rtl/fifo_frame_builder.sv
// fifo_frame_builder: pulls bytes from an upstream synchronous FIFO (1-cycle read latency)
// into a 2-entry output buffer and emits them as fixed-length frames with sop/eop markers.
// Optional feature macro: FRAME_CSUM_EN appends an XOR checksum byte to every frame.
module fifo_frame_builder #(
   parameter int unsigned FRAME_LEN = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_data,
   output logic        fifo_rd,
   output logic [7:0]  m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_sop,
   output logic        m_eop,
   output logic [15:0] frame_cnt
);

`ifdef FRAME_CSUM_EN
   typedef enum logic [1:0] {StIdle, StPayload, StCsum} state_e;
`else
   typedef enum logic {StIdle, StPayload} state_e;
`endif

   localparam logic [3:0] LastIdx = 4'(FRAME_LEN - 1);

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  buf_q [2];
   logic        wr_ptr_q, rd_ptr_q;
   logic [1:0]  count_q;
   logic        inflight_q;
   logic [15:0] frame_cnt_q;
   logic        buf_valid, pop, frame_done;
   logic [7:0]  head;
   logic [2:0]  occ_after;
`ifdef FRAME_CSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   assign buf_valid = (count_q != 2'd0);
   assign head      = buf_q[rd_ptr_q];
   assign frame_cnt = frame_cnt_q;

   // Occupancy counts this cycle's pop so a full-rate stream never bubbles; the read issued
   // now lands one cycle after the in-flight one, so occ_after < 2 still guarantees no overflow.
   assign occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign fifo_rd   = rst_n && !fifo_empty && (occ_after < 3'd2);

   // Frame FSM next-state and output decode
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      m_valid    = 1'b0;
      m_data     = 8'h00;
      m_sop      = 1'b0;
      m_eop      = 1'b0;
      pop        = 1'b0;
      frame_done = 1'b0;
`ifdef FRAME_CSUM_EN
      csum_d     = csum_q;
`endif
      unique case (state_q)
         StIdle: begin
            m_valid = buf_valid;
            m_data  = buf_valid ? head : 8'h00;
            m_sop   = buf_valid;
            if (buf_valid && m_ready) begin
               pop     = 1'b1;
               state_d = StPayload;
               idx_d   = 4'd1;
`ifdef FRAME_CSUM_EN
               csum_d  = head;
`endif
            end
         end
         StPayload: begin
            m_valid = buf_valid;
            m_data  = buf_valid ? head : 8'h00;
`ifndef FRAME_CSUM_EN
            m_eop   = buf_valid && (idx_q == LastIdx);
`endif
            if (buf_valid && m_ready) begin
               pop = 1'b1;
`ifdef FRAME_CSUM_EN
               csum_d = csum_q ^ head;
`endif
               if (idx_q == LastIdx) begin
                  idx_d = 4'd0;
`ifdef FRAME_CSUM_EN
                  state_d = StCsum;
`else
                  state_d    = StIdle;
                  frame_done = 1'b1;
`endif
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
`ifdef FRAME_CSUM_EN
         // Checksum byte comes from the XOR register; the buffer is not popped here.
         StCsum: begin
            m_valid = 1'b1;
            m_data  = csum_q;
            m_eop   = 1'b1;
            if (m_ready) begin
               state_d    = StIdle;
               csum_d     = 8'h00;
               frame_done = 1'b1;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // FSM state, byte index and checksum registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= 4'd0;
`ifdef FRAME_CSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
`ifdef FRAME_CSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   // Output buffer, in-flight read tracking and frame counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q[0]    <= 8'h00;
         buf_q[1]    <= 8'h00;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         inflight_q  <= 1'b0;
         frame_cnt_q <= 16'h0000;
      end else begin
         // Only bytes from reads we issued are captured; stale data after reset is ignored.
         if (inflight_q) begin
            buf_q[wr_ptr_q] <= fifo_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q    <= count_q + {1'b0, inflight_q} - {1'b0, pop};
         inflight_q <= fifo_rd;
         if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

endmodule

// File: doc/fifo_frame_builder.md
FIFO_FRAME_BUILDER -- requirements
Module: fifo_frame_builder

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 4, payload bytes per frame, legal range 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port fifo_empty  input  1  upstream sync FIFO empty flag.
REQ-005 SHALL have port fifo_data  input  8  upstream FIFO data_out; valid exactly one cycle after a granted read, 0 otherwise.
REQ-006 SHALL have port fifo_rd  output  1  read request to upstream FIFO.
REQ-007 SHALL have port m_data  output  8  frame byte.
REQ-008 SHALL have port m_valid  output  1  m_data valid.
REQ-009 SHALL have port m_ready  input  1  downstream accepts; transfer when m_valid && m_ready.
REQ-010 SHALL have port m_sop  output  1  first byte of frame, qualified by m_valid.
REQ-011 SHALL have port m_eop  output  1  last byte of frame, qualified by m_valid.
REQ-012 SHALL have port frame_cnt  output  16  count of completed frames (eop transfers).

Function
REQ-013 SHALL assert fifo_rd only when fifo_empty==0 and (buffer occupancy + reads in flight) < 2.
REQ-014 SHALL capture fifo_data into a 2-entry output buffer on the cycle after fifo_rd was asserted.
REQ-015 SHALL have fifo_rd high in cycle N produce m_valid no earlier than cycle N+2.
REQ-016 SHALL hold m_data, m_sop, m_eop stable while m_valid && !m_ready.
REQ-017 SHALL sustain one byte per cycle when fifo_empty==0 and m_ready==1 continuously.
REQ-018 SHALL never overflow the buffer and never drop or duplicate a byte under any m_ready pattern.
REQ-019 SHALL run FSM states IDLE, PAYLOAD, CSUM (CSUM only per REQ-028).
REQ-020 SHALL in IDLE present the first buffered byte with m_sop=1; on transfer go to PAYLOAD with byte index 1.
REQ-021 SHALL in PAYLOAD increment 4-bit byte index per transfer; the transfer at index FRAME_LEN-1 ends the payload.
REQ-022 SHALL, without the macro, assert m_eop on payload byte FRAME_LEN-1 and return to IDLE after its transfer.
REQ-023 SHALL increment frame_cnt by 1 on each eop transfer, wrapping 0xFFFF->0x0000.
REQ-024 SHALL keep fifo_rd low while fifo_empty==1; an empty FIFO mid-frame only stalls, the frame stays open.

Reset
REQ-025 SHALL on rst_n low immediately force fifo_rd=0, m_valid=0, m_data=0, m_sop=0, m_eop=0, frame_cnt=0, state IDLE, buffer empty, checksum 0.
REQ-026 SHALL discard in-flight reads and partial frames on reset mid-operation; the next output byte after release carries m_sop=1.
REQ-027 SHALL ignore a fifo_data byte arriving in the first cycle after reset release.

Configuration
REQ-028 SHALL, with FRAME_CSUM_EN defined, keep a running XOR of payload bytes, enter CSUM after payload byte FRAME_LEN-1 transfers (with m_eop=0), present the XOR with m_eop=1, return to IDLE on its transfer, and clear the XOR.
REQ-029 SHALL continue FIFO reads into the buffer during CSUM; buffer pops are blocked in CSUM.
REQ-030 SHALL, without FRAME_CSUM_EN, contain no checksum logic or CSUM state; frames are exactly FRAME_LEN bytes.

Verification
REQ-031 SHALL test: FIFO holds 0x11,0x22,0x33,0x44, m_ready=1, no macro -> 11(sop),22,33,44(eop) on consecutive cycles, frame_cnt=1.
REQ-032 SHALL test: same stimulus with FRAME_CSUM_EN -> 11(sop),22,33,44, then 0x44(eop); frame_cnt=1.
REQ-033 SHALL test: 8 bytes in FIFO, m_ready=0 for 20 cycles -> exactly 2 fifo_rd pulses, m_data=first byte stable; then m_ready=1 -> all 8 bytes in order as 2 frames.
REQ-034 SHALL test: fifo_empty=1 for 50 cycles -> fifo_rd=0, m_valid=0 throughout.
REQ-035 SHALL test: rst_n low after 2nd byte of a frame -> outputs 0 same cycle; after release, bytes 0xA0..0xA3 -> 0xA0 carries sop, frame_cnt=1.
REQ-036 SHALL test: random m_ready at 50% over 1000 bytes -> output stream equals input stream, frame_cnt=250 (FRAME_LEN=4).
